// File: rtl/mem_arbiter.sv
// Two-port (fetch / data) arbiter onto a single downstream memory port.
// One transaction outstanding at a time, round-robin on ties, with a response timeout.
module mem_arbiter #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_i_rd_w,
  input  logic [31:0] mem_i_pc_w,
  output logic        mem_i_accept_w,
  output logic        mem_i_valid_w,
  output logic        mem_i_error_w,
  output logic [31:0] mem_i_inst_w,
  input  logic        mem_d_rd_w,
  input  logic [3:0]  mem_d_wr_w,
  input  logic [31:0] mem_d_addr_w,
  input  logic [31:0] mem_d_data_wr_w,
  input  logic [10:0] mem_d_req_tag_w,
  output logic        mem_d_accept_w,
  output logic        mem_d_ack_w,
  output logic        mem_d_error_w,
  output logic [31:0] mem_d_data_rd_w,
  output logic [10:0] mem_d_resp_tag_w,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_we,
  input  logic        mem_accept,
  input  logic        mem_ack,
  input  logic        mem_error,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, WAIT_I, WAIT_D} state_t;

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic        last_d_q, last_d_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [10:0] tag_q, tag_d;

  logic i_pend, d_pend, grant_i, grant_d, tmo, resp;

  always_comb begin
    i_pend  = mem_i_rd_w;
    d_pend  = mem_d_rd_w | (|mem_d_wr_w);
    // On a tie the side that did not win the previous grant goes first.
    grant_d = (state_q == IDLE) && d_pend && (!i_pend || !last_d_q);
    grant_i = (state_q == IDLE) && i_pend && !grant_d;
    tmo     = (cnt_q == TMO_LAST);
    resp    = (state_q != IDLE) && (mem_ack || tmo);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      last_d_q <= 1'b1;
      cnt_q    <= 8'd0;
      tag_q    <= 11'd0;
    end else begin
      state_q  <= state_d;
      last_d_q <= last_d_d;
      cnt_q    <= cnt_d;
      tag_q    <= tag_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    last_d_d = last_d_q;
    cnt_d    = cnt_q;
    tag_d    = tag_q;
    case (state_q)
      IDLE: begin
        if ((grant_i || grant_d) && mem_accept) begin
          state_d  = grant_d ? WAIT_D : WAIT_I;
          last_d_d = grant_d;
          cnt_d    = 8'd0;
          if (grant_d) tag_d = mem_d_req_tag_w;
        end
      end
      WAIT_I, WAIT_D: begin
        if (resp) state_d = IDLE;
        else      cnt_d   = cnt_q + 8'd1;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are forced low while reset is held, even though they are combinational.
  always_comb begin
    mem_req          = 1'b0;
    mem_addr         = 32'd0;
    mem_wdata        = 32'd0;
    mem_we           = 4'd0;
    mem_i_accept_w   = 1'b0;
    mem_d_accept_w   = 1'b0;
    mem_i_valid_w    = 1'b0;
    mem_i_error_w    = 1'b0;
    mem_i_inst_w     = 32'd0;
    mem_d_ack_w      = 1'b0;
    mem_d_error_w    = 1'b0;
    mem_d_data_rd_w  = 32'd0;
    mem_d_resp_tag_w = 11'd0;
    if (rst_n) begin
      mem_req        = grant_i | grant_d;
      mem_i_accept_w = grant_i & mem_accept;
      mem_d_accept_w = grant_d & mem_accept;
      if (grant_d) begin
        mem_addr  = mem_d_addr_w;
        mem_wdata = mem_d_data_wr_w;
        mem_we    = mem_d_wr_w;
      end else if (grant_i) begin
        mem_addr = mem_i_pc_w;
      end
      if (resp && state_q == WAIT_I) begin
        mem_i_valid_w = 1'b1;
        mem_i_inst_w  = mem_ack ? mem_rdata : 32'd0;
        mem_i_error_w = mem_ack ? mem_error : 1'b1;
      end
      if (resp && state_q == WAIT_D) begin
        mem_d_ack_w      = 1'b1;
        mem_d_data_rd_w  = mem_ack ? mem_rdata : 32'd0;
        mem_d_error_w    = mem_ack ? mem_error : 1'b1;
        mem_d_resp_tag_w = tag_q;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios with literal expectations plus
// randomized traffic compared every cycle against a transaction-level model.
module tb_mem_arbiter;
  localparam int T = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mem_i_rd_w = 1'b0;
  logic [31:0] mem_i_pc_w = '0;
  logic        mem_d_rd_w = 1'b0;
  logic [3:0]  mem_d_wr_w = '0;
  logic [31:0] mem_d_addr_w = '0;
  logic [31:0] mem_d_data_wr_w = '0;
  logic [10:0] mem_d_req_tag_w = '0;
  logic        mem_accept = 1'b0;
  logic        mem_ack = 1'b0;
  logic        mem_error = 1'b0;
  logic [31:0] mem_rdata = '0;

  logic        mem_i_accept_w, mem_i_valid_w, mem_i_error_w;
  logic [31:0] mem_i_inst_w;
  logic        mem_d_accept_w, mem_d_ack_w, mem_d_error_w;
  logic [31:0] mem_d_data_rd_w;
  logic [10:0] mem_d_resp_tag_w;
  logic        mem_req;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_we;

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.TIMEOUT(T)) dut (
    .clk(clk), .rst_n(rst_n),
    .mem_i_rd_w(mem_i_rd_w), .mem_i_pc_w(mem_i_pc_w),
    .mem_i_accept_w(mem_i_accept_w), .mem_i_valid_w(mem_i_valid_w),
    .mem_i_error_w(mem_i_error_w), .mem_i_inst_w(mem_i_inst_w),
    .mem_d_rd_w(mem_d_rd_w), .mem_d_wr_w(mem_d_wr_w), .mem_d_addr_w(mem_d_addr_w),
    .mem_d_data_wr_w(mem_d_data_wr_w), .mem_d_req_tag_w(mem_d_req_tag_w),
    .mem_d_accept_w(mem_d_accept_w), .mem_d_ack_w(mem_d_ack_w),
    .mem_d_error_w(mem_d_error_w), .mem_d_data_rd_w(mem_d_data_rd_w),
    .mem_d_resp_tag_w(mem_d_resp_tag_w),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .mem_accept(mem_accept), .mem_ack(mem_ack), .mem_error(mem_error),
    .mem_rdata(mem_rdata)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level model ----------------
  // busy: a transaction is outstanding; own_d: it belongs to the data port;
  // last_d: the data port won the most recent grant; waited: wait cycles already spent.
  logic        m_busy, m_own_d, m_last_d;
  int          m_waited;
  logic [10:0] m_tag;
  int          cur_win;   // 0 none, 1 fetch, 2 data

  function automatic int winner(input logic busy, input logic last_d,
                                input logic i_p, input logic d_p);
    if (busy) return 0;
    if (i_p && d_p) return last_d ? 1 : 2;
    if (i_p) return 1;
    if (d_p) return 2;
    return 0;
  endfunction

  assign cur_win = winner(m_busy, m_last_d, mem_i_rd_w, mem_d_rd_w || (mem_d_wr_w != 4'd0));

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy   <= 1'b0;
      m_own_d  <= 1'b0;
      m_last_d <= 1'b1;
      m_waited <= 0;
      m_tag    <= '0;
    end else if (!m_busy) begin
      if (cur_win != 0 && mem_accept) begin
        m_busy   <= 1'b1;
        m_own_d  <= (cur_win == 2);
        m_last_d <= (cur_win == 2);
        m_waited <= 0;
        if (cur_win == 2) m_tag <= mem_d_req_tag_w;
      end
    end else if (mem_ack || m_waited + 1 >= T) begin
      m_busy <= 1'b0;
    end else begin
      m_waited <= m_waited + 1;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin : cmp
    logic        rsp, gi, gd, e_iv, e_dv, e_err;
    logic [31:0] e_data;
    if (!rst_n) begin
      chk("reset_outs", {31'd0, |{mem_req, mem_addr, mem_wdata, mem_we, mem_i_accept_w,
          mem_d_accept_w, mem_i_valid_w, mem_i_error_w, mem_i_inst_w, mem_d_ack_w,
          mem_d_error_w, mem_d_data_rd_w, mem_d_resp_tag_w}}, 32'd0);
    end else begin
      gi     = (cur_win == 1);
      gd     = (cur_win == 2);
      rsp    = m_busy && (mem_ack || m_waited + 1 >= T);
      e_iv   = rsp && !m_own_d;
      e_dv   = rsp && m_own_d;
      e_data = (rsp && mem_ack) ? mem_rdata : 32'd0;
      e_err  = rsp && (mem_ack ? mem_error : 1'b1);
      chk("mem_req",   32'(mem_req),        32'(gi || gd));
      chk("mem_addr",  mem_addr,            gd ? mem_d_addr_w : (gi ? mem_i_pc_w : 32'd0));
      chk("mem_wdata", mem_wdata,           gd ? mem_d_data_wr_w : 32'd0);
      chk("mem_we",    32'(mem_we),         gd ? 32'(mem_d_wr_w) : 32'd0);
      chk("i_accept",  32'(mem_i_accept_w), 32'(gi && mem_accept));
      chk("d_accept",  32'(mem_d_accept_w), 32'(gd && mem_accept));
      chk("i_valid",   32'(mem_i_valid_w),  32'(e_iv));
      chk("i_error",   32'(mem_i_error_w),  32'(e_iv && e_err));
      chk("i_inst",    mem_i_inst_w,        e_iv ? e_data : 32'd0);
      chk("d_ack",     32'(mem_d_ack_w),    32'(e_dv));
      chk("d_error",   32'(mem_d_error_w),  32'(e_dv && e_err));
      chk("d_data",    mem_d_data_rd_w,     e_dv ? e_data : 32'd0);
      chk("d_tag",     32'(mem_d_resp_tag_w), e_dv ? 32'(m_tag) : 32'd0);
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    mem_i_rd_w = 0; mem_i_pc_w = 0; mem_d_rd_w = 0; mem_d_wr_w = 0;
    mem_d_addr_w = 0; mem_d_data_wr_w = 0; mem_d_req_tag_w = 0;
    mem_accept = 0; mem_ack = 0; mem_error = 0; mem_rdata = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_n = 0;
    step();
    step();
    rst_n = 1;
  endtask

  logic exp_ia [8] = '{1, 0, 0, 0, 1, 0, 0, 0};
  logic exp_da [8] = '{0, 0, 1, 0, 0, 0, 1, 0};
  logic exp_iv [8] = '{0, 1, 0, 0, 0, 1, 0, 0};
  logic exp_dv [8] = '{0, 0, 0, 1, 0, 0, 0, 1};

  initial begin
    do_reset();
    @(negedge clk);
    chk("rst_state_req", 32'(mem_req), 32'd0);
    chk("rst_state_iv",  32'(mem_i_valid_w), 32'd0);

    // Fetch only, ack two cycles after accept
    step(); mem_i_rd_w = 1; mem_i_pc_w = 32'h100; mem_accept = 1;
    @(negedge clk);
    chk("f_req", 32'(mem_req), 32'd1);
    chk("f_addr", mem_addr, 32'h100);
    chk("f_we", 32'(mem_we), 32'd0);
    chk("f_acc", 32'(mem_i_accept_w), 32'd1);
    step(); clear_inputs();
    @(negedge clk);
    chk("f_wait_req", 32'(mem_req), 32'd0);
    step(); mem_ack = 1; mem_rdata = 32'h13;
    @(negedge clk);
    chk("f_valid", 32'(mem_i_valid_w), 32'd1);
    chk("f_inst", mem_i_inst_w, 32'h13);
    chk("f_err", 32'(mem_i_error_w), 32'd0);
    step(); clear_inputs();
    @(negedge clk);
    chk("f_pulse", 32'(mem_i_valid_w), 32'd0);
    $display("fetch transaction done");

    // Data write with tag
    step(); mem_d_wr_w = 4'hF; mem_d_addr_w = 32'h8000_0004;
    mem_d_data_wr_w = 32'hDEAD_BEEF; mem_d_req_tag_w = 11'h155; mem_accept = 1;
    @(negedge clk);
    chk("w_we", 32'(mem_we), 32'hF);
    chk("w_wdata", mem_wdata, 32'hDEAD_BEEF);
    chk("w_addr", mem_addr, 32'h8000_0004);
    step(); clear_inputs(); mem_ack = 1;
    @(negedge clk);
    chk("w_ack", 32'(mem_d_ack_w), 32'd1);
    chk("w_tag", 32'(mem_d_resp_tag_w), 32'h155);
    step(); clear_inputs();
    $display("data write transaction done");

    // Both pending continuously out of reset: I, D, I, D
    do_reset();
    mem_i_rd_w = 1; mem_i_pc_w = 32'h40; mem_d_rd_w = 1; mem_d_addr_w = 32'h80;
    mem_accept = 1; mem_ack = 1; mem_rdata = 32'h77;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk($sformatf("rr_iacc%0d", k), 32'(mem_i_accept_w), 32'(exp_ia[k]));
      chk($sformatf("rr_dacc%0d", k), 32'(mem_d_accept_w), 32'(exp_da[k]));
      chk($sformatf("rr_ival%0d", k), 32'(mem_i_valid_w), 32'(exp_iv[k]));
      chk($sformatf("rr_dack%0d", k), 32'(mem_d_ack_w), 32'(exp_dv[k]));
      step();
    end
    clear_inputs();
    $display("round-robin sequence done");

    // Data read timeout, then a late ack
    step(); mem_d_rd_w = 1; mem_d_addr_w = 32'h44; mem_d_req_tag_w = 11'h2A; mem_accept = 1;
    step(); clear_inputs(); mem_rdata = 32'hFFFF_FFFF;
    for (int k = 1; k <= T; k++) begin
      @(negedge clk);
      chk($sformatf("to_ack_w%0d", k), 32'(mem_d_ack_w), 32'(k == T));
      if (k == T) begin
        chk("to_err", 32'(mem_d_error_w), 32'd1);
        chk("to_data", mem_d_data_rd_w, 32'd0);
        chk("to_tag", 32'(mem_d_resp_tag_w), 32'h2A);
      end
      step();
    end
    mem_ack = 1;
    @(negedge clk);
    chk("late_ack_d", 32'(mem_d_ack_w), 32'd0);
    chk("late_ack_i", 32'(mem_i_valid_w), 32'd0);
    step(); clear_inputs();
    $display("timeout transaction done");

    // Stalled accept holds the request stable
    mem_i_rd_w = 1; mem_i_pc_w = 32'h200;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("st_req", 32'(mem_req), 32'd1);
      chk("st_acc", 32'(mem_i_accept_w), 32'd0);
      chk("st_addr", mem_addr, 32'h200);
      step();
    end
    mem_accept = 1;
    @(negedge clk);
    chk("st_acc_final", 32'(mem_i_accept_w), 32'd1);
    step(); clear_inputs(); mem_ack = 1; mem_rdata = 32'h5;
    @(negedge clk);
    chk("st_inst", mem_i_inst_w, 32'h5);
    step(); clear_inputs();
    $display("stalled fetch transaction done");

    // Reset while waiting on data, with an ack arriving in the same cycle
    mem_d_rd_w = 1; mem_d_addr_w = 32'h300; mem_accept = 1;
    step(); clear_inputs(); mem_i_rd_w = 1;
    @(negedge clk);
    chk("wd_req", 32'(mem_req), 32'd0);
    chk("wd_iacc", 32'(mem_i_accept_w), 32'd0);
    step(); mem_ack = 1; mem_rdata = 32'h99; mem_accept = 1;
    #1 rst_n = 0;
    #1;
    chk("ar_dack", 32'(mem_d_ack_w), 32'd0);
    chk("ar_req", 32'(mem_req), 32'd0);
    chk("ar_iacc", 32'(mem_i_accept_w), 32'd0);
    step(); step(); rst_n = 1; mem_d_rd_w = 1;
    @(negedge clk);
    chk("ar_tie_i", 32'(mem_i_accept_w), 32'd1);
    chk("ar_tie_d", 32'(mem_d_accept_w), 32'd0);
    chk("ar_ignored", 32'(mem_d_ack_w), 32'd0);
    // Now in WAIT_I after a fetch grant; reset again so the next tie must still go to fetch
    step(); mem_ack = 0;
    #1 rst_n = 0;
    step(); rst_n = 1;
    @(negedge clk);
    chk("ar2_tie_i", 32'(mem_i_accept_w), 32'd1);
    chk("ar2_tie_d", 32'(mem_d_accept_w), 32'd0);
    step(); clear_inputs();
    $display("reset-abandon sequence done");

    // Randomized traffic checked by the model every cycle
    for (int c = 0; c < 3000; c++) begin
      step();
      if (!rst_n) rst_n = 1;
      else if ($urandom_range(249) == 0) rst_n = 0;
      mem_i_rd_w      = ($urandom_range(99) < 60);
      mem_i_pc_w      = $urandom;
      case ($urandom_range(3))
        1:       begin mem_d_rd_w = 1; mem_d_wr_w = 0; end
        2:       begin mem_d_rd_w = 0; mem_d_wr_w = 4'($urandom_range(15, 1)); end
        default: begin mem_d_rd_w = 0; mem_d_wr_w = 0; end
      endcase
      mem_d_addr_w    = $urandom;
      mem_d_data_wr_w = $urandom;
      mem_d_req_tag_w = 11'($urandom_range(2047));
      mem_accept      = ($urandom_range(99) < 75);
      mem_ack         = ($urandom_range(99) < 30);
      mem_error       = 1'($urandom_range(1));
      mem_rdata       = $urandom;
    end
    step(); clear_inputs();
    rst_n = 1;
    step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255, giving the maximum cycles to wait for mem_ack before an error response is forced (range 1..255).
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1; reset is asynchronous and active-low.
REQ-004 SHALL have mem_i_rd_w in 1 (fetch request), mem_i_pc_w in 32 (fetch address), mem_i_accept_w out 1, mem_i_valid_w out 1, mem_i_error_w out 1, mem_i_inst_w out 32.
REQ-005 SHALL have mem_d_rd_w in 1, mem_d_wr_w in 4 (byte strobes), mem_d_addr_w in 32, mem_d_data_wr_w in 32, mem_d_req_tag_w in 11, mem_d_accept_w out 1, mem_d_ack_w out 1, mem_d_error_w out 1, mem_d_data_rd_w out 32, mem_d_resp_tag_w out 11.
REQ-006 SHALL have downstream shared port: mem_req out 1, mem_addr out 32, mem_wdata out 32, mem_we out 4, mem_accept in 1, mem_ack in 1, mem_error in 1, mem_rdata in 32.

Function
REQ-007 SHALL implement FSM states IDLE, WAIT_I, WAIT_D; at most one downstream transaction outstanding.
REQ-008 D request pending means mem_d_rd_w=1 or mem_d_wr_w!=0; I request pending means mem_i_rd_w=1.
REQ-009 In IDLE with one pending requester, that requester SHALL win; with both pending, the one not granted last (last_grant flag) SHALL win.
REQ-010 In IDLE the winner's address/data/strobes SHALL drive mem_addr/mem_wdata/mem_we combinationally with mem_req=1; I grant drives mem_we=0, mem_wdata=0.
REQ-011 Winner's upstream accept SHALL equal mem_accept in the same cycle; the loser's accept SHALL be 0.
REQ-012 On mem_req&mem_accept in IDLE: go WAIT_I or WAIT_D, update last_grant, capture mem_d_req_tag_w (D only), clear timeout counter.
REQ-013 In WAIT_x, mem_req SHALL be 0 and no upstream accept SHALL assert.
REQ-014 On mem_ack in WAIT_I: mem_i_valid_w=1, mem_i_inst_w=mem_rdata, mem_i_error_w=mem_error for that cycle (combinational); next state IDLE.
REQ-015 On mem_ack in WAIT_D: mem_d_ack_w=1, mem_d_data_rd_w=mem_rdata, mem_d_error_w=mem_error, mem_d_resp_tag_w=captured tag; next state IDLE.
REQ-016 Response outputs SHALL be 0 in every cycle without a response; response pulses SHALL last exactly one cycle.
REQ-017 Timeout counter (8 bit) SHALL increment each WAIT_x cycle without mem_ack; when it reaches TIMEOUT, issue the response of REQ-014/015 with error=1, data=0, and return to IDLE.
REQ-018 mem_ack received in IDLE (late response after timeout) SHALL be ignored and produce no upstream response.
REQ-019 mem_ack and timeout in the same cycle: mem_ack SHALL take precedence (real data, mem_error).
REQ-020 Arbitration latency: zero added cycles on request path; minimum one IDLE cycle between consecutive transactions.

Reset
REQ-021 rst_n=0 SHALL immediately force IDLE, counter=0, captured tag=0, last_grant=D (so I wins first tie), and all outputs 0.
REQ-022 Reset asserted in WAIT_x SHALL abandon the transaction; a subsequent mem_ack in IDLE SHALL be ignored per REQ-018.

Verification
REQ-023 I only: mem_i_rd_w=1, pc=0x0000_0100, mem_accept=1, ack 2 cycles later with rdata=0x0000_0013 -> mem_addr=0x100, mem_we=0, mem_i_valid_w pulse with inst 0x13, error 0.
REQ-024 D write: addr=0x8000_0004, data=0xDEAD_BEEF, wr=0xF, tag=0x155 -> mem_we=0xF, mem_wdata=0xDEADBEEF; on ack mem_d_ack_w=1, resp_tag=0x155.
REQ-025 Both pending continuously out of reset, immediate accept/ack -> grant order I, D, I, D; neither starves.
REQ-026 TIMEOUT=4, D read accepted, mem_ack never -> mem_d_ack_w=1 with error=1, data=0 on 4th wait cycle; later mem_ack ignored.
REQ-027 mem_accept=0 for 3 cycles with I pending -> mem_req held, mem_i_accept_w=0, state stays IDLE, address stable.
REQ-028 rst_n low mid-WAIT_D -> all outputs 0 immediately; after release, next tie grants I.
